// File: rtl/freq_gate_sched.sv
// -----------------------------------------------------------------------------
// freq_gate_sched
//
// Measurement sequencer for the edge-counting frequency datapath. It clears
// and enables an external pulse counter, times the gate window, waits for
// in-flight synchronised edges to land, then samples the count and offers it
// downstream on a valid/ready handshake. With auto-ranging enabled it switches
// between a long and a short gate according to the last count.
//
// Build option:
//   AUTORANGE_EN  defined   -> range switches between long/short gate using
//                              HI_THRESH / LO_THRESH with hysteresis.
//                 undefined -> long gate always, result_range always 0.
//
// Ports:
//   int_osc       in   clock (internal 48 MHz oscillator)
//   reset_n       in   asynchronous active-low reset
//   run           in   level, 1 = continuous measurement
//   edge_cnt      in   current value of the external (saturating) edge counter
//   cnt_clr       out  one-cycle synchronous clear strobe to the edge counter
//   cnt_en        out  count enable to the edge counter (high during the gate)
//   result_count  out  latched count
//   result_range  out  gate used for the result (0 long, 1 short)
//   result_valid  out  result available
//   result_ready  in   consumer accepts the result
//   busy          out  sequencer is not idle
//   overrun       out  sticky: an unaccepted result was overwritten
//   overrun_clr   in   clears overrun (a coincident set wins)
// -----------------------------------------------------------------------------
module freq_gate_sched #(
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned GATE_LONG_CYCLES  = 2_400_000,
    parameter int unsigned GATE_SHORT_CYCLES = 240_000,
    parameter int unsigned SETTLE_CYCLES     = 2,
    parameter int unsigned HI_THRESH         = 60_000,
    parameter int unsigned LO_THRESH         = 5_000
) (
    input  logic             int_osc,
    input  logic             reset_n,
    input  logic             run,
    input  logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic [CNT_W-1:0] result_count,
    output logic             result_range,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    // The timer also holds the settle length, so size it for the largest load.
    localparam int unsigned GATE_MAX = (GATE_LONG_CYCLES > GATE_SHORT_CYCLES) ?
                                       GATE_LONG_CYCLES : GATE_SHORT_CYCLES;
    localparam int unsigned LOAD_MAX = (GATE_MAX > SETTLE_CYCLES) ? GATE_MAX : SETTLE_CYCLES;
    localparam int unsigned TMR_W    = $clog2(LOAD_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_SETTLE,
        S_LATCH
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             range_q;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_range_q, res_range_d;
    logic             res_valid_q, res_valid_d;
    logic             overrun_q, overrun_d;

    // -------------------------------------------------------------------------
    // Next-state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        timer_d     = timer_q;
        res_count_d = res_count_q;
        res_range_d = res_range_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        if (res_valid_q && result_ready) begin
            res_valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (run) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                cnt_clr = 1'b1;
                if (!run) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    state_d = S_GATE;
                    timer_d = range_q ? TMR_W'(GATE_SHORT_CYCLES) : TMR_W'(GATE_LONG_CYCLES);
                end
            end

            S_GATE: begin
                cnt_en = 1'b1;
                if (!run) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(1)) begin
                    // A zero-length settle goes straight to the sample cycle.
                    state_d = (SETTLE_CYCLES == 0) ? S_LATCH : S_SETTLE;
                    timer_d = TMR_W'(SETTLE_CYCLES);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            S_SETTLE: begin
                if (!run) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(1)) begin
                    state_d = S_LATCH;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            S_LATCH: begin
                // A new result always loads. It only counts as an overrun when
                // the old one is still pending and not being taken this edge.
                res_count_d = edge_cnt;
                res_range_d = range_q;
                res_valid_d = 1'b1;
                if (res_valid_q && !result_ready) begin
                    overrun_d = 1'b1;   // after the clear above: set wins
                end
                state_d = run ? S_CLEAR : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Auto-ranging: decided on the sampled count, used from the next CLEAR.
    // -------------------------------------------------------------------------
`ifdef AUTORANGE_EN
    logic range_d;

    always_comb begin
        range_d = range_q;
        if (state_q == S_LATCH) begin
            // A saturated counter is always too fast for the long gate.
            if (!range_q && ((32'(edge_cnt) > HI_THRESH) || (&edge_cnt))) begin
                range_d = 1'b1;
            end else if (range_q && (32'(edge_cnt) < LO_THRESH)) begin
                range_d = 1'b0;
            end
        end
    end

    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            range_q <= 1'b0;
        end else begin
            range_q <= range_d;
        end
    end
`else
    assign range_q = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            res_count_q <= '0;
            res_range_q <= 1'b0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            timer_q     <= timer_d;
            res_count_q <= res_count_d;
            res_range_q <= res_range_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign result_count = res_count_q;
    assign result_range = res_range_q;
    assign result_valid = res_valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_gate_sched.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_sched
//
// Self-checking bench for freq_gate_sched with small gate lengths. Expected
// results are queued when a measurement is set up and compared when the DUT
// hands them over (valid & ready). The range model follows AUTORANGE_EN so the
// same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_freq_gate_sched;

    localparam int GL = 100;   // long gate
    localparam int GS = 10;    // short gate
    localparam int ST = 2;     // settle

    typedef struct {
        logic [7:0] cnt;
        logic       rng;
    } exp_t;

    logic       int_osc;
    logic       reset_n;
    logic       run;
    logic [7:0] edge_cnt;
    logic       cnt_clr;
    logic       cnt_en;
    logic [7:0] result_count;
    logic       result_range;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic       overrun;
    logic       overrun_clr;

    exp_t exp_q[$];
    bit   exp_range;
    int   n_checks;
    int   n_errors;

    freq_gate_sched #(
        .CNT_W             (8),
        .GATE_LONG_CYCLES  (GL),
        .GATE_SHORT_CYCLES (GS),
        .SETTLE_CYCLES     (ST),
        .HI_THRESH         (50),
        .LO_THRESH         (5)
    ) dut (
        .int_osc      (int_osc),
        .reset_n      (reset_n),
        .run          (run),
        .edge_cnt     (edge_cnt),
        .cnt_clr      (cnt_clr),
        .cnt_en       (cnt_en),
        .result_count (result_count),
        .result_range (result_range),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    initial int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit next_range(input bit r, input logic [7:0] c);
        bit nr;
        nr = r;
`ifdef AUTORANGE_EN
        if (!r && (c > 8'd50 || c == 8'hFF)) nr = 1'b1;
        else if (r && c < 8'd5) nr = 1'b0;
`else
        nr = 1'b0;
`endif
        return nr;
    endfunction

    // Scoreboard: sampled between the driving negedge and the next posedge,
    // so valid & ready here means the result is taken at that posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge int_osc);
            #2;
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_count", result_count, e.cnt);
                    check("sb_range", result_range, e.rng);
                end
            end
        end
    end

    // One measurement: waits (bounded) for CLEAR, checks the window shape and
    // latency, and leaves the caller at the cycle the result first shows.
    // result_ready is set to rdy a few cycles into the gate.
    task automatic run_meas(input logic [7:0] c, input logic rdy, input bit chk_lat);
        int gate;
        int t;
        int en_n;
        bit r_used;
        r_used = exp_range;
        gate   = r_used ? GS : GL;
        edge_cnt = c;
        exp_q.push_back('{cnt: c, rng: r_used});
        t = 0;
        while (!cnt_clr && t < 400) begin
            @(negedge int_osc);
            t++;
        end
        check("clr_seen", cnt_clr, 1);
        if (!cnt_clr) return;
        check("clr_en_off", cnt_en, 0);
        en_n = 0;
        for (int j = 1; j <= gate + ST + 2; j++) begin
            @(negedge int_osc);
            if (j == 5) result_ready = rdy;
            if (cnt_en) en_n++;
            if (j == 1) begin
                check("clr_width", cnt_clr, 0);
                check("gate_start", cnt_en, 1);
            end
            if (j == gate + 1) begin
                check("settle_en_off", cnt_en, 0);
                check("settle_busy", busy, 1);
            end
            if (chk_lat && j == gate + ST + 1) check("valid_early", result_valid, 0);
        end
        check("gate_len", en_n, gate);
        check("valid_lat", result_valid, 1);
        check("res_count", result_count, c);
        check("res_range", result_range, r_used);
        check("next_clr", cnt_clr, run);
        exp_range = next_range(exp_range, c);
    endtask

    initial begin
        int gate;
        n_checks     = 0;
        n_errors     = 0;
        exp_range    = 1'b0;
        reset_n      = 1'b0;
        run          = 1'b0;
        edge_cnt     = 8'd0;
        result_ready = 1'b1;
        overrun_clr  = 1'b0;

        // Reset state
        repeat (3) @(negedge int_osc);
        check("rst_clr", cnt_clr, 0);
        check("rst_en", cnt_en, 0);
        check("rst_valid", result_valid, 0);
        check("rst_count", result_count, 0);
        check("rst_range", result_range, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        @(negedge int_osc);
        check("idle_busy", busy, 0);
        run = 1'b1;

        // Basic measurement and range switching with hysteresis
        run_meas(8'd20, 1'b1, 1'b1);
        run_meas(8'd51, 1'b1, 1'b1);
        run_meas(8'd4, 1'b1, 1'b1);
        run_meas(8'd50, 1'b1, 1'b1);
        run_meas(8'd255, 1'b1, 1'b1);
        run_meas(8'd5, 1'b1, 1'b1);
        run_meas(8'd4, 1'b1, 1'b1);

        // Overwrite of an unaccepted result
        run_meas(8'd7, 1'b0, 1'b1);
        check("ovr_not_yet", overrun, 0);
        void'(exp_q.pop_front());   // result 7 is overwritten, never delivered
        run_meas(8'd9, 1'b0, 1'b0);
        check("ovr_set", overrun, 1);
        @(negedge int_osc);
        overrun_clr = 1'b1;
        @(negedge int_osc);
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("hold_valid", result_valid, 1);
        check("hold_count", result_count, 9);

        // Abort mid-gate: pending result must survive
        gate = exp_range ? GS : GL;
        for (int j = 3; j <= 40; j++) @(negedge int_osc);
        check("abort_pre_en", cnt_en, (gate >= 40) ? 1 : 0);
        run = 1'b0;
        @(negedge int_osc);
        check("abort_en", cnt_en, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", result_valid, 1);
        check("abort_count", result_count, 9);
        repeat (5) @(negedge int_osc);
        check("abort_idle_clr", cnt_clr, 0);
        check("abort_idle_busy", busy, 0);
        result_ready = 1'b1;
        @(negedge int_osc);
        @(negedge int_osc);
        check("abort_accepted", result_valid, 0);
        run = 1'b1;
        run_meas(8'd12, 1'b1, 1'b1);

        // Reset mid-settle with a pending result
        run_meas(8'd60, 1'b0, 1'b1);
        gate = exp_range ? GS : GL;
        for (int j = 1; j <= gate + 1; j++) @(negedge int_osc);
        check("pre_rst_en", cnt_en, 0);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", result_valid, 1);
        reset_n = 1'b0;
        #1;
        check("arst_valid", result_valid, 0);
        check("arst_count", result_count, 0);
        check("arst_range", result_range, 0);
        check("arst_busy", busy, 0);
        check("arst_en", cnt_en, 0);
        check("arst_overrun", overrun, 0);
        void'(exp_q.pop_front());   // result 60 dropped by reset
        exp_range = 1'b0;
        @(negedge int_osc);
        reset_n      = 1'b1;
        result_ready = 1'b1;
        run_meas(8'd20, 1'b1, 1'b1);

        run = 1'b0;
        repeat (5) @(negedge int_osc);
        check("sb_drained", exp_q.size(), 0);
        check("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_gate_sched.md
Name: freq_gate_sched

Overview:
- Measurement sequencer for the edge-counting frequency datapath.
- Drives the external pulse counter's clear/enable and times the gate window.
- Samples the count when the window ends, auto-ranges between a long gate and a short gate, and hands results downstream (e.g. LED bucket decoder) over a valid/ready handshake.
- Sits between the synchronised edge counter and the display/decode logic; runs from the internal 48 MHz oscillator clock.

Parameters:
- CNT_W, 16, width of edge counter value and result
- GATE_LONG_CYCLES, 2_400_000, range-0 gate length (50 ms at 48 MHz)
- GATE_SHORT_CYCLES, 240_000, range-1 gate length (5 ms at 48 MHz)
- SETTLE_CYCLES, 2, post-gate wait for in-flight synchronised edges to land in counter
- HI_THRESH, 60_000, range-0 count above which next gate is short
- LO_THRESH, 5_000, range-1 count below which next gate is long

Ports:
- int_osc  in  1  clock, 48 MHz
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = continuous measurement
- edge_cnt  in  CNT_W  current value of external edge counter (saturating)
- cnt_clr  out  1  synchronous clear strobe to edge counter
- cnt_en  out  1  count enable to edge counter
- result_count  out  CNT_W  latched count
- result_range  out  1  gate used for result (0 long, 1 short)
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE
- overrun  out  1  sticky: unaccepted result was overwritten
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, reset_n=0): state IDLE, range=0, all outputs 0, gate timer 0.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: run=1 -> CLEAR next cycle.
- CLEAR: exactly 1 cycle, cnt_clr=1, cnt_en=0; loads gate timer with GATE_LONG_CYCLES or GATE_SHORT_CYCLES per current range; -> GATE.
- GATE: cnt_en=1 for exactly the selected number of cycles; -> SETTLE.
- SETTLE: cnt_en=0 for SETTLE_CYCLES cycles; -> LATCH.
- LATCH: 1 cycle; edge_cnt sampled at this cycle's clock edge.
  - result_count and result_range (range used for this gate) register; result_valid=1 from next cycle.
  - -> CLEAR if run=1, else IDLE.
- Measurement period = 1 + gate + SETTLE_CYCLES + 1 cycles.
- Range update (at LATCH, takes effect from next CLEAR):
  - range 0 and (edge_cnt > HI_THRESH or edge_cnt all-ones) -> range 1.
  - range 1 and edge_cnt < LO_THRESH -> range 0.
  - Otherwise unchanged. Equality at either threshold: no change.
- Handshake:
  - result_valid drops the cycle after a clock edge with valid&ready=1.
  - Result registers are stable while valid=1 and not accepted, except on a new LATCH.
- Overwrite: LATCH while valid=1 and ready=0 overwrites result, keeps valid=1, and sets overrun.
  - LATCH coincident with acceptance (valid&ready=1 same edge): new result loaded, valid stays 1, no overrun.
- overrun clears on overrun_clr=1; if set and clear coincide, set wins.
- run deasserted during CLEAR/GATE/SETTLE: abort to IDLE next cycle.
  - cnt_en=0; no result produced; range unchanged; pending result and valid retained.
- run deasserted during LATCH: result still produced, then IDLE.
- Reset mid-operation: immediate return to reset values, including dropping a pending result.
- Timer: width sized by clog2 of the larger gate; counts down to 1; no wrap.

Optional Feature:
- AUTORANGE_EN defined: range switching as above.
- Not defined: range fixed at 0 (long gate always); result_range always 0; threshold compares removed; HI_THRESH/LO_THRESH ignored.

Test Plan (sim params GATE_LONG_CYCLES=100, GATE_SHORT_CYCLES=10, SETTLE_CYCLES=2, HI_THRESH=50, LO_THRESH=5, CNT_W=8, ready=1 unless stated):
- run=1 from reset, edge_cnt=20 -> cnt_clr 1 cycle; cnt_en high exactly 100 cycles; result_valid 104 cycles after CLEAR; result_count=20, range=0.
- Long gate, edge_cnt=51 -> range=0 result; next cnt_en window 10 cycles; that result has range=1. Then edge_cnt=4 -> following gate 100 cycles.
- Hysteresis: range 0 with edge_cnt=50 -> stays 0. Range 1 with edge_cnt=5 -> stays 1. edge_cnt=255 at range 0 -> range 1.
- ready=0 across two LATCHes (counts 7 then 9) -> result_count=9, valid=1, overrun=1. overrun_clr pulse -> overrun=0.
- run dropped mid-GATE (cycle 40) -> cnt_en low next cycle, IDLE, busy=0, no new valid. run re-raised -> fresh CLEAR, full 100-cycle gate.
- reset_n low mid-SETTLE with valid=1 -> all outputs 0 asynchronously; range=0 after release.
